// File: rtl/column_evaluator_if.sv
// Bundle between the column evaluator, the argument store and the result consumer.
// Latency: none, wiring only.
// Backpressure: none; the store answers reads combinationally in the same cycle.
interface column_evaluator_if #(
    parameter int ARG_COL_WIDTH  = 10,
    parameter int ARG_DATA_WIDTH = 16,
    parameter int RESULT_WIDTH   = 64
);
    // Control from the worksheet writer
    logic                      start;
    logic [ARG_COL_WIDTH-1:0]  last_col;

    // Argument store read port
    logic [ARG_COL_WIDTH-1:0]  rd_arg_col;
    logic [ARG_DATA_WIDTH-1:0] rd_arg_data_row0;
    logic [ARG_DATA_WIDTH-1:0] rd_arg_data_row1;
    logic [ARG_DATA_WIDTH-1:0] rd_arg_data_row2;
    logic                      rd_op_mul;

    // Result path
    logic                      busy;
    logic                      total_valid;
    logic [RESULT_WIDTH-1:0]   total;

    // Evaluator side
    modport slave (
        input  start,
        input  last_col,
        output rd_arg_col,
        input  rd_arg_data_row0,
        input  rd_arg_data_row1,
        input  rd_arg_data_row2,
        input  rd_op_mul,
        output busy,
        output total_valid,
        output total
    );

    // Environment side: writer, store and result consumer
    modport master (
        output start,
        output last_col,
        input  rd_arg_col,
        output rd_arg_data_row0,
        output rd_arg_data_row1,
        output rd_arg_data_row2,
        output rd_op_mul,
        input  busy,
        input  total_valid,
        input  total
    );
endinterface

// File: rtl/column_evaluator.sv
// Scans the three-row argument store column by column, applies each column's add/multiply and sums the results.
// Latency: total_valid rises at E(last_col+3) after the start edge E0; one column per cycle.
// Backpressure: none; start is ignored while busy, result is held until the next start.
module column_evaluator #(
    parameter int ARG_COL_WIDTH  = 10,
    parameter int ARG_DATA_WIDTH = 16,
    parameter int RESULT_WIDTH   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    column_evaluator_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [ARG_COL_WIDTH-1:0]  col;
    logic [ARG_COL_WIDTH-1:0]  last_q;

    // A start is only honoured when no scan is in flight
    logic                      start_acc;
    logic                      scanning;
    logic                      col_is_last;

    // Stage 1: captured store read for the column issued in the previous cycle
    logic                      s1_vld;
    logic [ARG_DATA_WIDTH-1:0] s1_row0;
    logic [ARG_DATA_WIDTH-1:0] s1_row1;
    logic [ARG_DATA_WIDTH-1:0] s1_row2;
    logic                      s1_mul;

    // Stage 2: per-column result
    logic                      s2_vld;
    logic [RESULT_WIDTH-1:0]   col_result;
    logic [RESULT_WIDTH-1:0]   col_result_next;

    // Stage 3: running grand total
    logic [RESULT_WIDTH-1:0]   acc;

    // Zero-extended operands so the product is formed at full result width
    logic [RESULT_WIDTH-1:0]   op0;
    logic [RESULT_WIDTH-1:0]   op1;
    logic [RESULT_WIDTH-1:0]   op2;

    assign start_acc   = bus.start && ((state == IDLE) || (state == DONE));
    assign scanning    = (state == SCAN);
    assign col_is_last = (col == last_q);

    assign op0 = RESULT_WIDTH'(s1_row0);
    assign op1 = RESULT_WIDTH'(s1_row1);
    assign op2 = RESULT_WIDTH'(s1_row2);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: scan until the last column is issued, then wait for the pipeline to empty
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (col_is_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Final column sits in stage 2 with nothing behind it: it accumulates on this edge
                if (!s1_vld && s2_vld) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next = SCAN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: busy spans SCAN and DRAIN, valid is simply being in DONE
    always_comb begin
        bus.busy        = 1'b0;
        bus.total_valid = 1'b0;
        case (state)
            SCAN:    bus.busy        = 1'b1;
            DRAIN:   bus.busy        = 1'b1;
            DONE:    bus.total_valid = 1'b1;
            default: begin
                bus.busy        = 1'b0;
                bus.total_valid = 1'b0;
            end
        endcase
    end

    assign bus.rd_arg_col = col;
    assign bus.total      = acc;

    // Column counter and latched column bound; counter stops at the bound so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            last_q <= '0;
        end else if (start_acc) begin
            col    <= '0;
            last_q <= bus.last_col;
        end else if (scanning && !col_is_last) begin
            col    <= col + ARG_COL_WIDTH'(1);
        end
    end

    // Stage 1: register the store outputs for the column addressed during SCAN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_row0 <= '0;
            s1_row1 <= '0;
            s1_row2 <= '0;
            s1_mul  <= 1'b0;
        end else begin
            s1_vld <= scanning;
            if (scanning) begin
                s1_row0 <= bus.rd_arg_data_row0;
                s1_row1 <= bus.rd_arg_data_row1;
                s1_row2 <= bus.rd_arg_data_row2;
                s1_mul  <= bus.rd_op_mul;
            end
        end
    end

    // Column operator; both forms wrap modulo 2**RESULT_WIDTH
    always_comb begin
        col_result_next = '0;
        if (s1_mul) begin
            col_result_next = op0 * op1 * op2;
        end else begin
            col_result_next = op0 + op1 + op2;
        end
    end

    // Stage 2: register the column result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld     <= 1'b0;
            col_result <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                col_result <= col_result_next;
            end
        end
    end

    // Stage 3: accumulate; a new start clears the previous total on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (start_acc) begin
            acc <= '0;
        end else if (s2_vld) begin
            acc <= acc + col_result;
        end
    end

endmodule

// File: tb/tb_column_evaluator.sv
// Directed bench: models the argument store as arrays and checks totals, latency and read addressing.
// Latency: measured in clock edges from the start edge to total_valid.
// Backpressure: none exercised; the DUT has none.
module tb_column_evaluator;

    localparam int CW = 10;
    localparam int DW = 16;
    localparam int RW = 64;
    localparam int NCOL = 1 << CW;
    localparam int TIMEOUT = 4000;

    logic clk;
    logic rst_n;

    column_evaluator_if #(.ARG_COL_WIDTH(CW), .ARG_DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus();

    column_evaluator #(.ARG_COL_WIDTH(CW), .ARG_DATA_WIDTH(DW), .RESULT_WIDTH(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [DW-1:0] mem0 [NCOL];
    logic [DW-1:0] mem1 [NCOL];
    logic [DW-1:0] mem2 [NCOL];
    logic          opm  [NCOL];

    assign bus.rd_arg_data_row0 = mem0[bus.rd_arg_col];
    assign bus.rd_arg_data_row1 = mem1[bus.rd_arg_col];
    assign bus.rd_arg_data_row2 = mem2[bus.rd_arg_col];
    assign bus.rd_op_mul        = opm[bus.rd_arg_col];

    int errors;
    int checks;

    logic [CW-1:0] col_seen [8];
    logic          busy_seen [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill_all(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                            input logic [DW-1:0] v2, input logic m);
        for (int i = 0; i < NCOL; i++) begin
            mem0[i] = v0;
            mem1[i] = v1;
            mem2[i] = v2;
            opm[i]  = m;
        end
    endtask

    task automatic load_aoc();
        fill_all(16'd0, 16'd0, 16'd0, 1'b0);
        mem0[0] = 16'd123; mem1[0] = 16'd45;  mem2[0] = 16'd6;   opm[0] = 1'b1;
        mem0[1] = 16'd328; mem1[1] = 16'd64;  mem2[1] = 16'd98;  opm[1] = 1'b0;
        mem0[2] = 16'd51;  mem1[2] = 16'd387; mem2[2] = 16'd215; opm[2] = 1'b1;
        mem0[3] = 16'd64;  mem1[3] = 16'd23;  mem2[3] = 16'd314; opm[3] = 1'b0;
    endtask

    // Pulses start (edge E0), then counts edges until total_valid; extra start
    // pulses are injected so they are sampled on edges E(ga+1) and E(gb+1).
    task automatic run_scan(input logic [CW-1:0] lc, input int ga, input int gb, output int lat);
        bus.last_col = lc;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        col_seen[0]  = bus.rd_arg_col;
        busy_seen[0] = bus.busy;
        while (!bus.total_valid && lat < TIMEOUT) begin
            if (lat == ga || lat == gb) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
            if (lat < 8) begin
                col_seen[lat]  = bus.rd_arg_col;
                busy_seen[lat] = bus.busy;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.last_col = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.total_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.total_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.total !== 64'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", bus.total); end
        checks++; if (bus.rd_arg_col !== 10'd0) begin errors++; $display("FAIL reset_col: got %0d want 0", bus.rd_arg_col); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_aoc();
        int lat;
        load_aoc();
        run_scan(10'd3, -1, -1, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL aoc_latency: got %0d want 6", lat); end
        checks++; if (bus.total !== 64'd4277556) begin errors++; $display("FAIL aoc_total: got %0d want 4277556", bus.total); end
        checks++; if (busy_seen[0] !== 1'b1) begin errors++; $display("FAIL aoc_busy_start: got %0b want 1", busy_seen[0]); end
        checks++; if (busy_seen[5] !== 1'b1) begin errors++; $display("FAIL aoc_busy_drain: got %0b want 1", busy_seen[5]); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL aoc_busy_done: got %0b want 0", bus.busy); end
        for (int k = 0; k < 6; k++) begin
            logic [CW-1:0] want;
            want = (k < 3) ? CW'(k) : CW'(3);
            checks++;
            if (col_seen[k] !== want) begin
                errors++;
                $display("FAIL aoc_col[%0d]: got %0d want %0d", k, col_seen[k], want);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.total_valid !== 1'b1 || bus.total !== 64'd4277556) begin
            errors++; $display("FAIL aoc_hold: got valid=%0b total=%0d want 1/4277556", bus.total_valid, bus.total); end
    endtask

    task automatic test_single();
        int lat;
        fill_all(16'd0, 16'd0, 16'd0, 1'b0);
        mem0[0] = 16'd2; mem1[0] = 16'd3; mem2[0] = 16'd4; opm[0] = 1'b1;
        run_scan(10'd0, -1, -1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL single_mul_latency: got %0d want 3", lat); end
        checks++; if (bus.total !== 64'd24) begin errors++; $display("FAIL single_mul_total: got %0d want 24", bus.total); end
        opm[0] = 1'b0;
        run_scan(10'd0, -1, -1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL single_add_latency: got %0d want 3", lat); end
        checks++; if (bus.total !== 64'd9) begin errors++; $display("FAIL single_add_total: got %0d want 9", bus.total); end
    endtask

    task automatic test_restart();
        int lat;
        // Enters from DONE with total=9 left by the previous task
        mem0[0] = 16'd1; mem1[0] = 16'd1; mem2[0] = 16'd1; opm[0] = 1'b0;
        bus.last_col = 10'd0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.total !== 64'd0) begin errors++; $display("FAIL restart_clear_total: got %0d want 0", bus.total); end
        checks++; if (bus.total_valid !== 1'b0) begin errors++; $display("FAIL restart_clear_valid: got %0b want 0", bus.total_valid); end
        lat = 0;
        while (!bus.total_valid && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL restart_latency: got %0d want 3", lat); end
        checks++; if (bus.total !== 64'd3) begin errors++; $display("FAIL restart_total: got %0d want 3", bus.total); end
    endtask

    task automatic test_extremes();
        int lat;
        fill_all(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        run_scan(10'd0, -1, -1, lat);
        checks++; if (bus.total !== 64'd281462092005375) begin
            errors++; $display("FAIL max_mul_total: got %0d want 281462092005375", bus.total); end
        fill_all(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        run_scan(10'd1023, -1, -1, lat);
        checks++; if (lat !== 1026) begin errors++; $display("FAIL full_scan_latency: got %0d want 1026", lat); end
        checks++; if (bus.total !== 64'd201323520) begin errors++; $display("FAIL full_scan_total: got %0d want 201323520", bus.total); end
        checks++; if (bus.rd_arg_col !== 10'd1023) begin errors++; $display("FAIL full_scan_col_hold: got %0d want 1023", bus.rd_arg_col); end
    endtask

    task automatic test_start_ignored();
        int lat;
        load_aoc();
        run_scan(10'd3, 1, 2, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL ignored_latency: got %0d want 6", lat); end
        checks++; if (bus.total !== 64'd4277556) begin errors++; $display("FAIL ignored_total: got %0d want 4277556", bus.total); end
    endtask

    task automatic test_async_reset();
        int lat;
        load_aoc();
        bus.last_col = 10'd3;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.rd_arg_col !== 10'd0) begin errors++; $display("FAIL async_col: got %0d want 0", bus.rd_arg_col); end
        checks++; if (bus.total !== 64'd0 || bus.total_valid !== 1'b0) begin
            errors++; $display("FAIL async_total: got %0d/%0b want 0/0", bus.total, bus.total_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        run_scan(10'd3, -1, -1, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL post_reset_latency: got %0d want 6", lat); end
        checks++; if (bus.total !== 64'd4277556) begin errors++; $display("FAIL post_reset_total: got %0d want 4277556", bus.total); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        fill_all(16'd0, 16'd0, 16'd0, 1'b0);
        test_reset();
        test_aoc();
        test_single();
        test_restart();
        test_extremes();
        test_start_ignored();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
